// File: rtl/servo_sweep_ctrl.sv
// servo_sweep_ctrl: multi-channel servo PWM with back-and-forth sweep, hold and slew-limited manual tracking.
// Define SERVO_SWEEP_ANTIPHASE_EN to start odd channels at MAX_US sweeping down.
module servo_sweep_ctrl #(
   parameter int CH          = 2,
   parameter int POS_W       = 11,
   parameter int CNT_W       = 15,
   parameter int PERIOD_US   = 20000,
   parameter int MIN_US      = 1000,
   parameter int MAX_US      = 2000,
   parameter int STEP_US     = 35,
   parameter int STEP_FRAMES = 10
) (
   input  logic                clk_us,
   input  logic                rst_n,
   input  logic                enable,
   input  logic [CH-1:0]       hold,
   input  logic [CH-1:0]       manual,
   input  logic [CH*POS_W-1:0] target,
   output logic [CH-1:0]       pwm_out,
   output logic [CH*POS_W-1:0] pos,
   output logic                frame_tk
);
   localparam int SW = $clog2(STEP_FRAMES + 1);
   localparam int PW = POS_W + 1;
   localparam logic [PW-1:0] MIN_E = PW'(MIN_US);
   localparam logic [PW-1:0] MAX_E = PW'(MAX_US);
   localparam logic [PW-1:0] STP_E = PW'(STEP_US);

   typedef enum logic [1:0] {UP, DOWN, HOLD, TRACK} state_t;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SW-1:0]    stp_q, stp_d;
   logic             tk, ev;

   assign tk       = enable && cnt_q == CNT_W'(PERIOD_US - 1);
   assign ev       = tk && stp_q == SW'(STEP_FRAMES - 1);
   assign frame_tk = tk;

   always_comb begin
      cnt_d = (!enable || tk) ? '0 : cnt_q + 1'b1;
      stp_d = !enable ? '0 : !tk ? stp_q : ev ? '0 : stp_q + 1'b1;
   end

   always_ff @(posedge clk_us or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         stp_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         stp_q <= stp_d;
      end
   end

   for (genvar g = 0; g < CH; g++) begin : g_ch
`ifdef SERVO_SWEEP_ANTIPHASE_EN
      localparam bit ODD = (g % 2) == 1;
`else
      localparam bit ODD = 1'b0;
`endif
      logic [POS_W-1:0] pos_q, pos_d;
      state_t           st_q, st_d;
      logic             dn_q, dn_d;
      logic             pwm_q;
      logic [PW-1:0]    p, t, tgt, up_v, dn_v;
      logic             d;

      always_comb begin
         p     = {1'b0, pos_q};
         t     = {1'b0, target[g*POS_W +: POS_W]};
         tgt   = t < MIN_E ? MIN_E : t > MAX_E ? MAX_E : t;
         up_v  = p + STP_E >= MAX_E ? MAX_E : p + STP_E;
         dn_v  = p < MIN_E + STP_E ? MIN_E : p - STP_E;
         // direction after leaving TRACK is derived from where tracking left the servo
         d     = st_q == TRACK ? p == MAX_E : dn_q;
         pos_d = pos_q;
         st_d  = st_q;
         dn_d  = dn_q;
         if (ev) begin
            if (manual[g]) begin
               st_d  = TRACK;
               pos_d = POS_W'(p < tgt ? (tgt - p > STP_E ? p + STP_E : tgt)
                                      : (p - tgt > STP_E ? p - STP_E : tgt));
            end else if (hold[g]) begin
               st_d = HOLD;
               dn_d = d;
            end else begin
               pos_d = POS_W'(d ? dn_v : up_v);
               dn_d  = d ? dn_v != MIN_E : up_v == MAX_E;
               st_d  = dn_d ? DOWN : UP;
            end
         end
      end

      always_ff @(posedge clk_us or negedge rst_n) begin
         if (!rst_n) begin
            pos_q <= POS_W'(ODD ? MAX_US : MIN_US);
            st_q  <= ODD ? DOWN : UP;
            dn_q  <= ODD;
            pwm_q <= 1'b0;
         end else begin
            pos_q <= pos_d;
            st_q  <= st_d;
            dn_q  <= dn_d;
            pwm_q <= enable && (32'(cnt_q) < 32'(pos_q));
         end
      end

      assign pwm_out[g]             = pwm_q;
      assign pos[g*POS_W +: POS_W]  = pos_q;
   end
endmodule
